serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/adderfull.sv | 13 +
 rtl/serial_adder.sv | 115 +++++++++++
 tb/tb_serial_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/adderfull.sv
// One-bit combinational full adder used as the bit-slice of the serial adder.
module adderfull (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// WIDTH-bit adder that pushes one operand bit per clock through adderfull, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  logic [WIDTH-1:0]   sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic               done_r;
  logic               c_out_r;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic               accept_s;
  logic [WIDTH-1:0]   b_load_s;
  logic               carry_load_s;

  adderfull u_bit (
    .a     (a_sr_r[0]),
    .b     (b_sr_r[0]),
    .c_in  (carry_r),
    .sum   (fa_sum_s),
    .c_out (fa_cout_s)
  );

  // Start is honoured whenever no bits are in flight, including the done cycle.
  assign accept_s = start & ((state_r == IDLE) | (state_r == DONE));
  assign busy     = (state_r == RUN);
  assign done     = done_r;
  assign sum      = sum_r;
  assign c_out    = c_out_r;

  // Operand B and carry seed at load time; subtract is a + ~b + 1.
  always_comb begin
    b_load_s     = b;
    carry_load_s = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = c_in;
    end
`endif
  end

  // Control FSM, operand shifters, carry flop and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      done_r  <= 1'b0;
      c_out_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s) begin
        a_sr_r  <= a;
        b_sr_r  <= b_load_s;
        carry_r <= carry_load_s;
        cnt_r   <= '0;
        sum_r   <= '0;
        state_r <= RUN;
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          RUN: begin
            sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
            carry_r <= fa_cout_s;
            a_sr_r  <= a_sr_r >> 1;
            b_sr_r  <= b_sr_r >> 1;
            cnt_r   <= cnt_r + 1'b1;
            if (cnt_r == LAST_CNT) begin
              c_out_r <= fa_cout_s;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= RUN;
            end
          end
          DONE:    state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor pops them on done.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] hold_sum;
  logic         hold_c;
  bit           hold_valid = 1'b0;
  int           run_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ic, input logic is, input int due);
    exp_t r;
    longint unsigned t;
    if (is) begin
      r.s = ia - ib;
      r.c = (ia >= ib);
    end else begin
      t   = 64'(ia) + 64'(ib) + 64'(ic);
      r.s = t[W-1:0];
      r.c = t[W];
    end
    r.due = due;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; start is held across one rising edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input bit track);
    a     = ia;
    b     = ib;
    c_in  = ic;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = is;
`endif
    start = 1'b1;
    if (!busy && track) q.push_back(model(ia, ib, ic, is, cyc + 9));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: result/latency on done, busy length, and result hold while idle.
  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
      run_len    = 0;
    end else begin
      if (busy) begin
        run_len++;
      end else if (run_len != 0) begin
        checks++;
        if (run_len != W) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles expected %0d", run_len, W);
        end
        run_len = 0;
      end
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: sum=%h c_out=%b with no request outstanding", sum, c_out);
        end else begin
          e = q.pop_front();
          if (sum !== e.s || c_out !== e.c || cyc != e.due) begin
            errors++;
            $display("FAIL result: got sum=%h c_out=%b cyc=%0d expected sum=%h c_out=%b cyc=%0d",
                     sum, c_out, cyc, e.s, e.c, e.due);
          end
        end
        hold_sum   = sum;
        hold_c     = c_out;
        hold_valid = 1'b1;
      end else if (busy) begin
        hold_valid = 1'b0;
      end else if (hold_valid) begin
        checks++;
        if (sum !== hold_sum || c_out !== hold_c) begin
          errors++;
          $display("FAIL hold: got sum=%h c_out=%b expected sum=%h c_out=%b",
                   sum, c_out, hold_sum, hold_c);
        end
      end
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    bit           seen;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(c_out), 64'd0);

    issue(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_drain(30);
    issue(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_drain(30);
    issue(8'hA5, 8'h5B, 1'b1, 1'b0, 1'b1);
    wait_drain(30);
    repeat (20) @(negedge clk);

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    issue(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    issue(8'h10, 8'h10, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) issue(8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
    wait_drain(30);

    // Reset in the third RUN cycle discards the operation.
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(c_out), 64'd0);
    repeat (15) @(negedge clk);
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    wait_drain(30);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
    wait_drain(30);
    issue(8'h01, 8'h02, 1'b1, 1'b1, 1'b1);
    wait_drain(30);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      issue(ra, rb, rc, rs, 1'b1);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
